// File: rtl/fetch_if.sv
// Fetch-stage control bundle: back-end/pre-decoder status in, stall/flush controls
// and performance counters out. The controller uses master; the fetch datapath uses slave.
interface fetch_if #(
  parameter int CNT_W = 32
);
  logic             full_ififo;
  logic             isJump_pre;
  logic             valid_predict_pre;
  logic             mispredict_rob;
  logic             stall_backend;
  logic             backend_clear;
  logic             stall_pc;
  logic             stall_bpu;
  logic             stall_ifr;
  logic             flush_pc;
  logic             flush_ifr;
  logic             flush_ififo;
  logic             stall_ififo;
  logic [CNT_W-1:0] cnt_redirect;
  logic [CNT_W-1:0] cnt_flush;
  logic [CNT_W-1:0] cnt_stall;

  modport master (
    input  full_ififo, isJump_pre, valid_predict_pre, mispredict_rob,
           stall_backend, backend_clear,
    output stall_pc, stall_bpu, stall_ifr, flush_pc, flush_ifr, flush_ififo,
           stall_ififo, cnt_redirect, cnt_flush, cnt_stall
  );

  modport slave (
    output full_ififo, isJump_pre, valid_predict_pre, mispredict_rob,
           stall_backend, backend_clear,
    input  stall_pc, stall_bpu, stall_ifr, flush_pc, flush_ifr, flush_ififo,
           stall_ififo, cnt_redirect, cnt_flush, cnt_stall
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: turns FIFO occupancy, redirects and mispredict
// recovery into stall/flush controls, and keeps saturating fetch-loss counters.
module fetch_ctrl #(
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  fif
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_STALL   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;
  localparam logic [3:0] RCNT_LOAD  = 4'(RECOVER_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_redirect_q, cnt_redirect_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic stall_fe;
  logic flush_pc, flush_ifr, flush_ififo, stall_ififo;
  logic in_recover, redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d        = state_q;
    rcnt_d         = rcnt_q;
    cnt_redirect_d = cnt_redirect_q;
    cnt_flush_d    = cnt_flush_q;
    cnt_stall_d    = cnt_stall_q;
    stall_fe       = 1'b0;
    flush_pc       = 1'b0;
    flush_ifr      = 1'b0;
    flush_ififo    = 1'b0;
    stall_ififo    = 1'b0;
    in_recover     = (state_q == ST_RECOVER);
    redirect       = fif.isJump_pre | fif.valid_predict_pre;

    if (fif.mispredict_rob) begin
      flush_pc    = 1'b1;
      flush_ifr   = 1'b1;
      flush_ififo = 1'b1;
      stall_ififo = 1'b1;
      state_d     = ST_RECOVER;
      rcnt_d      = RCNT_LOAD;
      cnt_flush_d = sat_inc(cnt_flush_q);
    end else begin
      stall_ififo = fif.stall_backend | in_recover;
      if (in_recover && rcnt_q != 4'd0)
        rcnt_d = rcnt_q - 4'd1;
      if (fif.full_ififo) begin
        // Redirects are dropped here; the held IF register re-presents them later.
        stall_fe    = 1'b1;
        cnt_stall_d = sat_inc(cnt_stall_q);
        if (!in_recover)
          state_d = ST_STALL;
      end else begin
        if (redirect) begin
          flush_ifr      = 1'b1;
          cnt_redirect_d = sat_inc(cnt_redirect_q);
        end
        if (!in_recover)
          state_d = ST_RUN;
        else if (rcnt_q == 4'd0 && fif.backend_clear)
          state_d = ST_RUN;
      end
    end

    // Controls are forced quiet for as long as reset is held.
    if (rst) begin
      stall_fe    = 1'b0;
      flush_pc    = 1'b0;
      flush_ifr   = 1'b0;
      flush_ififo = 1'b0;
      stall_ififo = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      rcnt_q         <= 4'd0;
      cnt_redirect_q <= '0;
      cnt_flush_q    <= '0;
      cnt_stall_q    <= '0;
    end else begin
      state_q        <= state_d;
      rcnt_q         <= rcnt_d;
      cnt_redirect_q <= cnt_redirect_d;
      cnt_flush_q    <= cnt_flush_d;
      cnt_stall_q    <= cnt_stall_d;
    end
  end

  assign fif.stall_pc     = stall_fe;
  assign fif.stall_bpu    = stall_fe;
  assign fif.stall_ifr    = stall_fe;
  assign fif.flush_pc     = flush_pc;
  assign fif.flush_ifr    = flush_ifr;
  assign fif.flush_ififo  = flush_ififo;
  assign fif.stall_ififo  = stall_ififo;
  assign fif.cnt_redirect = cnt_redirect_q;
  assign fif.cnt_flush    = cnt_flush_q;
  assign fif.cnt_stall    = cnt_stall_q;

endmodule
